// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the IF/DM memory port arbiter.
// Tie-break policy is selected in the top by ARB_RR_EN.
package mem_arb_pkg;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_tmo.sv
// arb_timeout_cnt: counts busy cycles of one memory access.
// expire_o flags the last cycle an access may wait for mem_ack.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between IF and DM.
// Define ARB_RR_EN for round-robin ties; default is fixed DM priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy, resp, grant, pick_dm, expire;

    assign busy  = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign resp  = (state_q == RESP);
    assign grant = (state_q == IDLE) && (if_req || dm_req);

`ifdef ARB_RR_EN
    grant_t last_q, last_d;

    // On a tie the port that lost last time wins.
    assign pick_dm = dm_req && (!if_req || last_q == GNT_IF);

    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = pick_dm ? GNT_DM : GNT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= GNT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    if (pick_dm) begin
                        gnt_d   = GNT_DM;
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        state_d = BUSY_DM;
                    end else begin
                        gnt_d   = GNT_IF;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        state_d = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                // A late ack on the expiry cycle still counts as success.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (expire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (grant),
        .en_i     (busy),
        .expire_o (expire)
    );

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;

    assign if_ack   = resp && (gnt_q == GNT_IF);
    assign dm_ack   = resp && (gnt_q == GNT_DM);
    assign if_rdata = if_ack ? rdata_q : '0;
    assign dm_rdata = dm_ack ? rdata_q : '0;
    assign err      = resp && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a transaction model.
// Build with ARB_RR_EN defined to check round-robin tie-breaking.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
        logic          err;
        int            at;
    } exp_t;

    exp_t sb[$];
    logic glog[$];
    exp_t me;

    // requester inputs as seen at the last rising edge
    logic          s_if = 1'b0;
    logic          s_dm = 1'b0;
    logic          s_we = 1'b0;
    logic [AW-1:0] s_ifa = '0;
    logic [AW-1:0] s_dma = '0;
    logic [DW-1:0] s_wd = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        s_if  <= if_req;
        s_dm  <= dm_req;
        s_we  <= dm_we;
        s_ifa <= if_addr;
        s_dma <= dm_addr;
        s_wd  <= dm_wdata;
    end

    // memory responder / model state
    logic          active = 1'b0;
    int            elapsed = 0;
    int            lat = 0;
    logic          exp_port = 1'b0;
    logic          last_m = 1'b0;
    logic          snap_we = 1'b0;
    logic [AW-1:0] snap_addr = '0;
    logic [DW-1:0] snap_wd = '0;
    int            force_lat = -1;
    logic          force_rd_en = 1'b0;
    logic [DW-1:0] force_rd = '0;

    // requester configuration
    logic en_if = 1'b0;
    logic en_dm = 1'b0;
    int   pct = 0;
    int   left_if = -1;
    int   left_dm = -1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return TO + 1;
        if (r == 1) return TO;
        if (r == 2) return TO - 1;
        return $urandom_range(1, 4);
    endfunction

    task automatic step();
        logic          p;
        logic [DW-1:0] rd;
        @(negedge clk);
        if (!active && mem_req) begin
            chk("grant_src", s_if || s_dm, 1);
            if (s_if && s_dm) begin
`ifdef ARB_RR_EN
                p = (last_m == 1'b0);
`else
                p = 1'b1;
`endif
            end else begin
                p = s_dm;
            end
            last_m = p;
            glog.push_back(p);
            exp_port  = p;
            snap_we   = p ? s_we : 1'b0;
            snap_addr = p ? s_dma : s_ifa;
            snap_wd   = s_wd;
            active    = 1'b1;
            elapsed   = 0;
            lat       = (force_lat >= 0) ? force_lat : pick_lat();
        end
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (active) begin
            elapsed++;
            chk("mem_req_held", mem_req, 1);
            chk("mem_we", mem_we, snap_we);
            chk("mem_addr", mem_addr, snap_addr);
            if (exp_port) chk("mem_wdata", mem_wdata, snap_wd);
            if (elapsed == lat) begin
                rd        = force_rd_en ? force_rd : DW'($urandom);
                mem_ack   = 1'b1;
                mem_rdata = rd;
                sb.push_back('{exp_port, rd, 1'b0, cyc + 1});
                active    = 1'b0;
            end else if (elapsed == TO) begin
                sb.push_back('{exp_port, '0, 1'b1, cyc + 1});
                active = 1'b0;
            end
        end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
        end
        if (if_ack) if_req = 1'b0;
        if (dm_ack) dm_req = 1'b0;
        // the granted requester's fields may wander once latched
        if (active && !exp_port && if_req && $urandom_range(0, 1) == 1)
            if_addr = $urandom;
        if (active && exp_port && dm_req && $urandom_range(0, 1) == 1) begin
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = ~dm_we;
        end
        if (!if_req && en_if && left_if != 0 &&
            $urandom_range(0, 99) < pct) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
            if (left_if > 0) left_if--;
        end
        if (!dm_req && en_dm && left_dm != 0 &&
            $urandom_range(0, 99) < pct) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
            if (left_dm > 0) left_dm--;
        end
    endtask

    task automatic run_until_quiet(input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!if_req && !dm_req && !active && !mem_req && sb.size() == 0)
                break;
        end
        step();
        chk("drain", {if_req, dm_req, active, mem_req, sb.size() != 0}, 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].at < cyc) begin
            chk("ack_missing", cyc, sb[0].at);
            void'(sb.pop_front());
        end
        if (if_ack || dm_ack) begin
            chk("ack_onehot", if_ack && dm_ack, 0);
            chk("ack_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                me = sb.pop_front();
                chk("ack_port", dm_ack, me.port);
                chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, me.rdata);
                chk("ack_err", err, me.err);
                chk("ack_cycle", cyc, me.at);
            end
        end else if (err) begin
            chk("err_without_ack", err, 0);
        end
    end

    int eo[4];
    int n;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b1;

        // simultaneous requests, two per port, immediately re-raised
        glog.delete();
        en_if = 1'b1; en_dm = 1'b1; pct = 100;
        left_if = 2; left_dm = 2; force_lat = 1;
        run_until_quiet(100);
`ifdef ARB_RR_EN
        eo = '{1, 0, 1, 0};
`else
        eo = '{1, 1, 0, 0};
`endif
        chk("tie_count", glog.size(), 4);
        if (glog.size() == 4)
            for (int i = 0; i < 4; i++) chk("tie_order", glog[i], eo[i]);
        en_if = 1'b0; en_dm = 1'b0;

        // single fetch, zero-wait memory
        force_lat = 1; force_rd_en = 1'b1; force_rd = 32'h2008_0005;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        step();
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_mem_addr", mem_addr, 32'h40);
        chk("fetch_mem_we", mem_we, 0);
        step();
        chk("fetch_if_ack", if_ack, 1);
        chk("fetch_if_rdata", if_rdata, 32'h2008_0005);
        chk("fetch_err", err, 0);
        chk("fetch_dm_ack", dm_ack, 0);
        step();
        chk("fetch_idle", {mem_req, if_ack}, 0);

        // store with three-cycle memory
        force_lat = 3;
        dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_mem_req", mem_req, 1);
            chk("st_mem_we", mem_we, 1);
            chk("st_mem_addr", mem_addr, 32'h100);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        step();
        chk("st_dm_ack", dm_ack, 1);
        chk("st_if_ack", if_ack, 0);
        chk("st_mem_req_off", mem_req, 0);
        step();

        // dead memory: timeout
        force_lat = 100; force_rd_en = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_req) n++;
            else break;
        end
        chk("tmo_len", n, TO);
        chk("tmo_dm_ack", dm_ack, 1);
        chk("tmo_err", err, 1);
        chk("tmo_rdata", dm_rdata, 0);
        step();
        chk("tmo_idle", {mem_req, dm_ack, err}, 0);

        // ack arriving on the expiry cycle
        force_lat = TO; force_rd_en = 1'b1; force_rd = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h0000_0800;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_req) n++;
            else break;
        end
        chk("edge_len", n, TO);
        chk("edge_if_ack", if_ack, 1);
        chk("edge_err", err, 0);
        chk("edge_rdata", if_rdata, 32'h1234_5678);
        step();

        // reset in the middle of a data access
        force_lat = 100; force_rd_en = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_0001;
        repeat (3) step();
        chk("mid_busy", mem_req, 1);
        rst = 1'b0; dm_req = 1'b0;
        active = 1'b0; last_m = 1'b0;
        step();
        chk("mid_mem_req", mem_req, 0);
        chk("mid_no_ack", {dm_ack, err}, 0);
        rst = 1'b1;
        step();
        chk("mid_after_quiet", {mem_req, dm_ack, if_ack, err}, 0);
        force_lat = 2;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        run_until_quiet(50);

        // random traffic
        force_lat = -1;
        en_if = 1'b1; en_dm = 1'b1; pct = 50;
        left_if = -1; left_dm = -1;
        repeat (600) step();
        en_if = 1'b0; en_dm = 1'b0;
        run_until_quiet(200);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage pipeline.
- Provides request/acknowledge handshakes to both requesters and a hold-until-ack contract the hazard logic uses to freeze PC and IF/ID.
- Adds a response timeout with an error flag so a dead memory cannot hang the pipeline.
- Sits between the pipeline's IF/MEM stages and the memory model.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, byte-address width
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetched word, valid with if_ack
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle data completion pulse
dm_rdata  out  DATA_W  load data, valid with dm_ack
err  out  1  one-cycle pulse with ack when the access timed out
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0; timeout counter 0; last-grant register = IF.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE: arbitration happens when any req is high.
  - dm_req wins over if_req (older instruction first).
  - Grant latches address, we, and wdata into registers (we forced 0 for IF). Go to BUSY_x.
  - mem_req rises the cycle after the req is first sampled, so minimum req-to-mem_req latency is 1.
- BUSY_x:
  - mem_req=1; mem_we/addr/wdata come from latched registers and are stable for the whole access.
  - Counter increments each cycle.
  - On mem_ack: capture mem_rdata, clear mem_req, go to RESP.
  - Else, when counter == TIMEOUT-1: clear mem_req, set rdata=0 and err, go to RESP.
  - mem_ack in the same cycle as the timeout: ack wins, err=0.
- RESP:
  - For exactly one cycle, the granted port's ack=1 and rdata is valid; err is valid in the same cycle. The other port's ack stays 0.
  - Go to IDLE; requests are not sampled in RESP.
- Requester rule: deassert req in the cycle after ack. A req still high in IDLE is a new request.
- Latency with a zero-wait memory (mem_ack in the first BUSY cycle): req sampled at t, mem_req at t+1, ack at t+2, IDLE at t+3.
- Steady state: both requesters pending, one access per 3 cycles.
- Input changes after grant are ignored.
- mem_ack outside BUSY is ignored.
- Reset mid-access: mem_req drops at once; no ack or err is issued for the aborted access.
- Counter width is clog2(TIMEOUT); it is cleared on entry to BUSY.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: on simultaneous if_req and dm_req, grant goes to the port not granted last. The last-grant register updates at each grant and resets to IF, so DM gets the first tie.
- Undefined: fixed DM priority; no last-grant register is synthesised.
- A single requester is always granted immediately in both modes.

Decomposition:
- Shared package mem_arb_pkg:
  - enum arb_state_t {IDLE, BUSY_IF, BUSY_DM, RESP}.
  - enum grant_t {GNT_IF, GNT_DM}.
  - Default TIMEOUT constant.
- One natural sub-module: arb_timeout_cnt (clear, enable, expire output). The FSM and datapath registers stay in the top.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x0000_0040 at t, mem_rdata=0x2008_0005 with mem_ack at t+1 -> mem_req at t+1 with addr 0x40, we=0; if_ack=1 and if_rdata=0x2008_0005 at t+2; err=0.
- Store with 3-cycle memory latency: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> mem_req held 3 cycles with we=1 and data stable; dm_ack the cycle after mem_ack; if_ack stays 0.
- Simultaneous if_req and dm_req for 4 accesses:
  - Without ARB_RR_EN: grant order DM, DM (if dm_req is re-raised), then IF.
  - With ARB_RR_EN: order DM, IF, DM, IF.
- Timeout: TIMEOUT=16, memory never acks -> mem_req high exactly 16 cycles; next cycle ack=1, err=1, rdata=0; FSM back in IDLE after that.
- Ack on the timeout edge: mem_ack in cycle 16 of the access -> ack=1, err=0, rdata equals mem_rdata.
- Reset mid-access: rst=0 for one cycle during BUSY_DM -> mem_req=0 next cycle; no dm_ack or err pulse; a new request after reset proceeds normally.
